// File: rtl/lsu_controller_pkg.sv
// lsu_controller_pkg: shared types and helpers for the rv32i_sc data-port LSU.
// State encoding, access-size codes and the func3 unsigned-bit position live
// here so the controller, the lane aligner and the bench agree on them.
// Build option: LSU_MISALIGNED_SPLIT_EN (see lsu_controller.sv).
package lsu_controller_pkg;

   localparam int DATA_WIDTH_DEF     = 32;
   localparam int MEM_ADDR_WIDTH_DEF = 10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ACC0  = 3'd1,
      ST_WAIT0 = 3'd2,
      ST_ACC1  = 3'd3,
      ST_WAIT1 = 3'd4,
      ST_DONE  = 3'd5
   } lsu_state_e;

   // Size codes are func3[1:0]; 2'b11 is treated as a word.
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int F3_UNSIGNED_BIT = 2;

   // Byte-lane mask of an access of the given size at offset 0.
   function automatic logic [3:0] size_mask(input logic [1:0] sz);
      case (sz)
         SZ_BYTE: size_mask = 4'b0001;
         SZ_HALF: size_mask = 4'b0011;
         default: size_mask = 4'b1111;
      endcase
   endfunction

   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      case (sz)
         SZ_BYTE: size_bytes = 3'd1;
         SZ_HALF: size_bytes = 3'd2;
         default: size_bytes = 3'd4;
      endcase
   endfunction

   // Address not a multiple of the access size.
   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
      case (sz)
         SZ_BYTE: is_misaligned = 1'b0;
         SZ_HALF: is_misaligned = off[0];
         default: is_misaligned = (off != 2'b00);
      endcase
   endfunction

   // Access runs past the end of its word.
   function automatic logic is_crossing(input logic [1:0] sz, input logic [1:0] off);
      is_crossing = (({2'b00, off} + {1'b0, size_bytes(sz)}) > 4'd4);
   endfunction

endpackage

// File: rtl/lsu_controller_if.sv
// lsu_controller_if: request/response and BRAM-port bundle of the LSU.
// Handshake: the core presents a request with req_valid; stall is the inverse
// of ready. A request is taken in the cycle req_valid is high while the LSU is
// idle, and the core must hold the pipeline while stall is high. rsp_valid is
// a one-cycle completion pulse with rsp_rdata/misaligned_err valid alongside.
// mem_rdata is returned by the BRAM the cycle after a read enable.
interface lsu_controller_if
   import lsu_controller_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_DEF
);
   logic                      req_valid;
   logic                      req_we;
   logic [2:0]                req_func3;
   logic [DATA_WIDTH-1:0]     req_addr;
   logic [DATA_WIDTH-1:0]     req_wdata;
   logic                      stall;
   logic                      rsp_valid;
   logic [DATA_WIDTH-1:0]     rsp_rdata;
   logic                      misaligned_err;
   logic                      mem_en;
   logic [3:0]                mem_we;
   logic [MEM_ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0]     mem_wdata;
   logic [DATA_WIDTH-1:0]     mem_rdata;

   // Core + BRAM side.
   modport master (
      output req_valid, req_we, req_func3, req_addr, req_wdata, mem_rdata,
      input  stall, rsp_valid, rsp_rdata, misaligned_err,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   // LSU controller side.
   modport slave (
      input  req_valid, req_we, req_func3, req_addr, req_wdata, mem_rdata,
      output stall, rsp_valid, rsp_rdata, misaligned_err,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for the LSU.
// Store side: shifts the lane mask and write data into a two-word window,
// low word for the first access, high word for the second.
// Load side: selects the addressed bytes out of {hi, lo} and extends them.
// hi only needs its low three bytes: no access reaches beyond them.
module lsu_lane_align
   import lsu_controller_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic [1:0]            offset_i,
   input  logic [1:0]            size_i,
   input  logic                  unsigned_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [DATA_WIDTH-1:0] lo_i,
   input  logic [DATA_WIDTH-9:0] hi_i,
   output logic [3:0]            mask_lo_o,
   output logic [3:0]            mask_hi_o,
   output logic [DATA_WIDTH-1:0] data_lo_o,
   output logic [DATA_WIDTH-1:0] data_hi_o,
   output logic [DATA_WIDTH-1:0] rdata_o
);
   logic [7:0]              mask8;
   logic [2*DATA_WIDTH-1:0] data_w;
   logic [DATA_WIDTH-1:0]   win;

   // Store lanes: mask and data shifted by the byte offset.
   always_comb begin
      mask8  = {4'b0000, size_mask(size_i)} << offset_i;
      data_w = {{DATA_WIDTH{1'b0}}, wdata_i} << {offset_i, 3'b000};
   end

   assign mask_lo_o = mask8[3:0];
   assign mask_hi_o = mask8[7:4];
   assign data_lo_o = data_w[DATA_WIDTH-1:0];
   assign data_hi_o = data_w[2*DATA_WIDTH-1:DATA_WIDTH];

   // Load bytes: window {hi, lo} >> 8*offset, then truncate and extend.
   always_comb begin
      case (offset_i)
         2'd0:    win = lo_i;
         2'd1:    win = {hi_i[7:0],  lo_i[DATA_WIDTH-1:8]};
         2'd2:    win = {hi_i[15:0], lo_i[DATA_WIDTH-1:16]};
         default: win = {hi_i[23:0], lo_i[DATA_WIDTH-1:24]};
      endcase
      case (size_i)
         SZ_BYTE: rdata_o = unsigned_i ? {{(DATA_WIDTH-8){1'b0}}, win[7:0]}
                                       : {{(DATA_WIDTH-8){win[7]}}, win[7:0]};
         SZ_HALF: rdata_o = unsigned_i ? {{(DATA_WIDTH-16){1'b0}}, win[15:0]}
                                       : {{(DATA_WIDTH-16){win[15]}}, win[15:0]};
         default: rdata_o = win;
      endcase
   end

endmodule

// File: rtl/lsu_controller.sv
// lsu_controller: sequences one load/store onto a byte-enabled BRAM port with
// one-cycle read latency, stalling the core until the access completes.
// Build option LSU_MISALIGNED_SPLIT_EN: when defined, word-crossing accesses
// are split into two BRAM accesses; when undefined, any misaligned access is
// rejected with misaligned_err and the second-access states are not built.
// All outputs except stall are registered; mem_* values are computed from the
// state being entered so they appear in the cycle of the access state.
module lsu_controller
   import lsu_controller_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_DEF
) (
   input  logic           clk,
   input  logic           rst,
   lsu_controller_if.slave bus,
   output lsu_state_e     dbg_state_o
);
   lsu_state_e state_q, state_d;

   // Latched request.
   logic                      we_q;
   logic [2:0]                func3_q;
   logic [1:0]                off_q;
   logic [MEM_ADDR_WIDTH-1:0] idx_q;
   logic [DATA_WIDTH-1:0]     wdata_q;
   logic [DATA_WIDTH-1:0]     lo_q;

   // Registered outputs.
   logic                      mem_en_q, mem_en_d;
   logic [3:0]                mem_we_q, mem_we_d;
   logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
   logic                      rsp_valid_q;
   logic [DATA_WIDTH-1:0]     rsp_rdata_q, rdata_d;

   // Request fields: live inputs while idle (the accept cycle), latched after.
   logic                      is_idle;
   logic                      src_we;
   logic [2:0]                src_f3;
   logic [1:0]                src_off;
   logic [MEM_ADDR_WIDTH-1:0] src_idx;
   logic [DATA_WIDTH-1:0]     src_wdata;
   logic [1:0]                src_size;
   logic                      unused_addr_hi;

   logic [3:0]                mask_lo, mask_hi;
   logic [DATA_WIDTH-1:0]     data_lo, data_hi, ext_rdata, lo_sel;
   logic [DATA_WIDTH-9:0]     hi_sel;

   assign is_idle   = (state_q == ST_IDLE);
   assign src_we    = is_idle ? bus.req_we : we_q;
   assign src_f3    = is_idle ? bus.req_func3 : func3_q;
   assign src_off   = is_idle ? bus.req_addr[1:0] : off_q;
   assign src_idx   = is_idle ? bus.req_addr[MEM_ADDR_WIDTH+1:2] : idx_q;
   assign src_wdata = is_idle ? bus.req_wdata : wdata_q;
   assign src_size  = src_f3[1:0];
   assign unused_addr_hi = ^bus.req_addr[DATA_WIDTH-1:MEM_ADDR_WIDTH+2];

   // Read data is taken straight from the BRAM in the capture cycle.
   assign lo_sel = (state_q == ST_WAIT0) ? bus.mem_rdata : lo_q;

`ifdef LSU_MISALIGNED_SPLIT_EN
   logic                  cross;
   logic [DATA_WIDTH-9:0] hi_q;

   assign cross  = is_crossing(src_size, src_off);
   assign hi_sel = (state_q == ST_WAIT1) ? bus.mem_rdata[DATA_WIDTH-9:0] : hi_q;
   assign bus.misaligned_err = 1'b0;
`else
   logic misal;
   logic err_q, err_d;

   assign misal  = is_misaligned(src_size, src_off);
   assign hi_sel = '0;
   assign bus.misaligned_err = err_q;
`endif

   lsu_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .offset_i   (src_off),
      .size_i     (src_size),
      .unsigned_i (src_f3[F3_UNSIGNED_BIT]),
      .wdata_i    (src_wdata),
      .lo_i       (lo_sel),
      .hi_i       (hi_sel),
      .mask_lo_o  (mask_lo),
      .mask_hi_o  (mask_hi),
      .data_lo_o  (data_lo),
      .data_hi_o  (data_hi),
      .rdata_o    (ext_rdata)
   );

   // Next state and completion data.
   always_comb begin
      state_d = state_q;
      rdata_d = '0;
`ifndef LSU_MISALIGNED_SPLIT_EN
      err_d   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
               state_d = ST_ACC0;
`else
               if (misal) begin
                  state_d = ST_DONE;
                  err_d   = 1'b1;
               end else begin
                  state_d = ST_ACC0;
               end
`endif
            end
         end
         ST_ACC0: begin
            if (!we_q) begin
               state_d = ST_WAIT0;
            end else begin
`ifdef LSU_MISALIGNED_SPLIT_EN
               state_d = cross ? ST_ACC1 : ST_DONE;
`else
               state_d = ST_DONE;
`endif
            end
         end
         ST_WAIT0: begin
`ifdef LSU_MISALIGNED_SPLIT_EN
            if (cross) begin
               state_d = ST_ACC1;
            end else begin
               state_d = ST_DONE;
               rdata_d = ext_rdata;
            end
`else
            state_d = ST_DONE;
            rdata_d = ext_rdata;
`endif
         end
`ifdef LSU_MISALIGNED_SPLIT_EN
         ST_ACC1: begin
            state_d = we_q ? ST_DONE : ST_WAIT1;
         end
         ST_WAIT1: begin
            state_d = ST_DONE;
            rdata_d = ext_rdata;
         end
`endif
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // BRAM port values for the state being entered.
   always_comb begin
      mem_en_d    = (state_d == ST_ACC0) || (state_d == ST_ACC1);
      mem_we_d    = '0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if (state_d == ST_ACC0) begin
         mem_addr_d  = src_idx;
         mem_wdata_d = data_lo;
         mem_we_d    = src_we ? mask_lo : 4'b0000;
      end else if (state_d == ST_ACC1) begin
         mem_addr_d  = src_idx + 1'b1;
         mem_wdata_d = data_hi;
         mem_we_d    = src_we ? mask_hi : 4'b0000;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Request latch on accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q    <= 1'b0;
         func3_q <= '0;
         off_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
      end else if (is_idle && bus.req_valid) begin
         we_q    <= bus.req_we;
         func3_q <= bus.req_func3;
         off_q   <= bus.req_addr[1:0];
         idx_q   <= bus.req_addr[MEM_ADDR_WIDTH+1:2];
         wdata_q <= bus.req_wdata;
      end
   end

   // Load data capture; the high word is cleared on accept so it reads 0 when unused.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lo_q <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
         hi_q <= '0;
`endif
      end else begin
         if (state_q == ST_WAIT0) lo_q <= bus.mem_rdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
         if (is_idle && bus.req_valid)   hi_q <= '0;
         else if (state_q == ST_WAIT1)   hi_q <= bus.mem_rdata[DATA_WIDTH-9:0];
`endif
      end
   end

   // Output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_en_q    <= 1'b0;
         mem_we_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
`ifndef LSU_MISALIGNED_SPLIT_EN
         err_q       <= 1'b0;
`endif
      end else begin
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_valid_q <= (state_d == ST_DONE);
         rsp_rdata_q <= rdata_d;
`ifndef LSU_MISALIGNED_SPLIT_EN
         err_q       <= err_d;
`endif
      end
   end

   assign bus.stall     = (!is_idle && state_q != ST_DONE) || (is_idle && bus.req_valid);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_lsu_controller.sv
// tb_lsu_controller: directed vector table plus hand-written sequences for the
// BRAM access trace, crossing accesses and reset in the middle of a load.
// Expectations follow the build option LSU_MISALIGNED_SPLIT_EN.
module tb_lsu_controller;
   import lsu_controller_pkg::*;

`ifdef LSU_MISALIGNED_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lsu_controller_if #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(10)) bus ();
   lsu_state_e dbg_state;

   lsu_controller #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(10)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // ---------------- BRAM model ----------------
   logic [31:0] mem [1024];
   logic        pl_en = 1'b0;
   logic [9:0]  pl_idx = '0;
   logic [31:0] pl_data = '0;

   initial bus.mem_rdata = '0;

   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_idx] <= pl_data;
      end else if (bus.mem_en) begin
         if (bus.mem_we == 4'b0000) begin
            bus.mem_rdata <= mem[bus.mem_addr];
         end else begin
            for (int b = 0; b < 4; b++)
               if (bus.mem_we[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
         end
      end
   end

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [63:0] exp_q[$];
   logic [63:0] act_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Packs one BRAM access as {cycle, addr, we, wdata}.
   function automatic logic [63:0] pk(input int c, input logic [9:0] a,
                                      input logic [3:0] w, input logic [31:0] d);
      logic [7:0] c8;
      c8 = 8'(c);
      return {c8, 6'b0, a, 4'b0, w, d};
   endfunction

   task automatic chk_trace(input string name);
      chk({name, "_count"}, 64'(act_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
         chk($sformatf("%s_acc%0d", name, i), act_q[i], exp_q[i]);
   endtask

   // ---------------- driver tasks ----------------
   task automatic preload(input logic [9:0] idx, input logic [31:0] val);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = idx; pl_data = val;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // Issues one request, records every BRAM access, waits (bounded) for rsp_valid.
   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic er, output logic stall_ok);
      act_q.delete();
      stall_ok = 1'b1; lat = -1; rd = '0; er = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_func3 = f3;
      bus.req_addr = addr; bus.req_wdata = wd;
      #1;
      if (bus.stall !== 1'b1) stall_ok = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) begin
            // Busy-time request changes must be ignored.
            bus.req_valid = 1'b0;
            bus.req_we    = 1'($urandom_range(1));
            bus.req_func3 = 3'($urandom_range(7));
            bus.req_addr  = $urandom;
            bus.req_wdata = $urandom;
         end
         if (bus.mem_en) act_q.push_back(pk(c, bus.mem_addr, bus.mem_we, bus.mem_wdata));
         if (bus.rsp_valid) begin
            lat = c; rd = bus.rsp_rdata; er = bus.misaligned_err;
            if (bus.stall !== 1'b0) stall_ok = 1'b0;
            break;
         end else if (bus.stall !== 1'b1) begin
            stall_ok = 1'b0;
         end
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string       name;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [9:0]  p0_idx;
      logic [31:0] p0_w;
      logic [9:0]  p1_idx;
      logic [31:0] p1_w;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
      logic [31:0] exp_w0;
      logic [31:0] exp_w1;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int          lat;
      logic [31:0] rd;
      logic        er;
      logic        sok;
      int          rsp_seen;

      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_func3 = '0;
      bus.req_addr = '0; bus.req_wdata = '0;

      // name, we, f3, addr, wdata, p0_idx, p0_w, p1_idx, p1_w, exp_rd, exp_err, exp_lat, exp_w0, exp_w1
      vecs.push_back('{"lw_aligned", 1'b0, 3'b010, 32'h10, 32'h0, 10'd4, 32'hDEADBEEF, 10'd100, 32'h01010101,
                       32'hDEADBEEF, 1'b0, 3, 32'hDEADBEEF, 32'h01010101});
      vecs.push_back('{"sb_lane3", 1'b1, 3'b000, 32'h23, 32'h000000A5, 10'd8, 32'h11223344, 10'd100, 32'h01010101,
                       32'h0, 1'b0, 2, 32'hA5223344, 32'h01010101});
      vecs.push_back('{"lh_signed", 1'b0, 3'b001, 32'h06, 32'h0, 10'd1, 32'h80011234, 10'd2, 32'h000000AB,
                       32'hFFFF8001, 1'b0, 3, 32'h80011234, 32'h000000AB});
      vecs.push_back('{"lhu", 1'b0, 3'b101, 32'h06, 32'h0, 10'd1, 32'h80011234, 10'd2, 32'h000000AB,
                       32'h00008001, 1'b0, 3, 32'h80011234, 32'h000000AB});
      vecs.push_back('{"lb_off1", 1'b0, 3'b000, 32'h05, 32'h0, 10'd1, 32'h80011234, 10'd2, 32'h000000AB,
                       32'h00000012, 1'b0, 3, 32'h80011234, 32'h000000AB});
      vecs.push_back('{"lb_off3_neg", 1'b0, 3'b000, 32'h07, 32'h0, 10'd1, 32'h80011234, 10'd2, 32'h000000AB,
                       32'hFFFFFF80, 1'b0, 3, 32'h80011234, 32'h000000AB});
      vecs.push_back('{"lbu_off3", 1'b0, 3'b100, 32'h07, 32'h0, 10'd1, 32'h80011234, 10'd2, 32'h000000AB,
                       32'h00000080, 1'b0, 3, 32'h80011234, 32'h000000AB});
      vecs.push_back('{"sh_upper", 1'b1, 3'b001, 32'h0A, 32'h1234BEEF, 10'd2, 32'h55555555, 10'd100, 32'h01010101,
                       32'h0, 1'b0, 2, 32'hBEEF5555, 32'h01010101});
      vecs.push_back('{"sw_aligned", 1'b1, 3'b010, 32'h0C, 32'hCAFEF00D, 10'd3, 32'h0, 10'd100, 32'h01010101,
                       32'h0, 1'b0, 2, 32'hCAFEF00D, 32'h01010101});
      vecs.push_back('{"sb_f3_bit2", 1'b1, 3'b100, 32'h21, 32'h000000EE, 10'd8, 32'h0, 10'd100, 32'h01010101,
                       32'h0, 1'b0, 2, 32'h0000EE00, 32'h01010101});
      vecs.push_back('{"lw_cross", 1'b0, 3'b010, 32'h0D, 32'h0, 10'd3, 32'h44332211, 10'd4, 32'h88776655,
                       SPLIT ? 32'h55443322 : 32'h0, !SPLIT, SPLIT ? 5 : 1, 32'h44332211, 32'h88776655});
      vecs.push_back('{"lh_misal_in_word", 1'b0, 3'b001, 32'h05, 32'h0, 10'd1, 32'h80011234, 10'd2, 32'h000000AB,
                       SPLIT ? 32'h00000112 : 32'h0, !SPLIT, SPLIT ? 3 : 1, 32'h80011234, 32'h000000AB});
      vecs.push_back('{"lh_cross", 1'b0, 3'b001, 32'h07, 32'h0, 10'd1, 32'h80011234, 10'd2, 32'h000000AB,
                       SPLIT ? 32'hFFFFAB80 : 32'h0, !SPLIT, SPLIT ? 5 : 1, 32'h80011234, 32'h000000AB});
      vecs.push_back('{"sw_cross_wrap", 1'b1, 3'b010, 32'hFFE, 32'hAABBCCDD, 10'd1023, 32'h11111111, 10'd0, 32'h22222222,
                       32'h0, !SPLIT, SPLIT ? 3 : 1,
                       SPLIT ? 32'hCCDD1111 : 32'h11111111, SPLIT ? 32'h2222AABB : 32'h22222222});

      // ---------------- reset state ----------------
      repeat (3) @(negedge clk);
      chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
      chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_err", 64'(bus.misaligned_err), 64'd0);
      chk("rst_stall_low", 64'(bus.stall), 64'd0);
      bus.req_valid = 1'b1;
      #1;
      chk("rst_stall_follows_req", 64'(bus.stall), 64'd1);
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // ---------------- table ----------------
      foreach (vecs[i]) begin
         preload(vecs[i].p0_idx, vecs[i].p0_w);
         preload(vecs[i].p1_idx, vecs[i].p1_w);
         run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, rd, er, sok);
         chk({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].exp_lat));
         chk({vecs[i].name, "_rdata"}, 64'(rd), 64'(vecs[i].exp_rd));
         chk({vecs[i].name, "_err"}, 64'(er), 64'(vecs[i].exp_err));
         chk({vecs[i].name, "_stall"}, 64'(sok), 64'd1);
         @(negedge clk);
         chk({vecs[i].name, "_word0"}, 64'(mem[vecs[i].p0_idx]), 64'(vecs[i].exp_w0));
         chk({vecs[i].name, "_word1"}, 64'(mem[vecs[i].p1_idx]), 64'(vecs[i].exp_w1));
      end

      // ---------------- BRAM access traces ----------------
      preload(10'd4, 32'hDEADBEEF);
      run_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er, sok);
      exp_q.delete();
      exp_q.push_back(pk(1, 10'd4, 4'b0000, 32'h0));
      chk_trace("trace_lw");

      run_req(1'b1, 3'b000, 32'h23, 32'h000000A5, lat, rd, er, sok);
      exp_q.delete();
      exp_q.push_back(pk(1, 10'd8, 4'b1000, 32'hA5000000));
      chk_trace("trace_sb");

      run_req(1'b1, 3'b010, 32'hFFE, 32'hAABBCCDD, lat, rd, er, sok);
      exp_q.delete();
      if (SPLIT) begin
         exp_q.push_back(pk(1, 10'd1023, 4'b1100, 32'hCCDD0000));
         exp_q.push_back(pk(2, 10'd0, 4'b0011, 32'h0000AABB));
      end
      chk_trace("trace_sw_cross");

      preload(10'd3, 32'h44332211);
      preload(10'd4, 32'h88776655);
      run_req(1'b0, 3'b010, 32'h0D, 32'h0, lat, rd, er, sok);
      exp_q.delete();
      if (SPLIT) begin
         exp_q.push_back(pk(1, 10'd3, 4'b0000, 32'h0));
         exp_q.push_back(pk(3, 10'd4, 4'b0000, 32'h0));
      end
      chk_trace("trace_lw_cross");

      // ---------------- reset during WAIT0 ----------------
      preload(10'd4, 32'h0BADF00D);
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_func3 = 3'b010;
      bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("abort_in_wait0", 64'(dbg_state), 64'(ST_WAIT0));
      rst = 1'b1;
      #1;
      chk("abort_mem_en", 64'(bus.mem_en), 64'd0);
      chk("abort_mem_we", 64'(bus.mem_we), 64'd0);
      chk("abort_mem_addr", 64'(bus.mem_addr), 64'd0);
      chk("abort_mem_wdata", 64'(bus.mem_wdata), 64'd0);
      chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("abort_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
      chk("abort_err", 64'(bus.misaligned_err), 64'd0);
      chk("abort_stall", 64'(bus.stall), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      rsp_seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.rsp_valid) rsp_seen++;
      end
      chk("abort_no_rsp", 64'(rsp_seen), 64'd0);
      run_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er, sok);
      chk("after_abort_latency", 64'(lat), 64'd3);
      chk("after_abort_rdata", 64'(rd), 64'h0BADF00D);
      chk("after_abort_stall", 64'(sok), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
